// File: rtl/counter_timp.sv
// counter_timp
// Hours:minutes time-of-day counter for the go-home timer datapath.
// Either of two external times can be loaded; afterwards the counter
// advances one minute every TICKS_PER_MIN clock cycles, up or down,
// and presents the hours in 24 h or 12 h display format.
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   reset        synchronous active-low reset
//   timp_ore1    hours of load source 1 (0..23)
//   timp_minute1 minutes of load source 1 (0..59)
//   timp_ore2    hours of load source 2 (0..23)
//   timp_minute2 minutes of load source 2 (0..59)
//   load_1       load source 1 (level, highest priority)
//   load_2       load source 2 (level, used only when load_1 is low)
//   s12          1 = 12 h display on out_ore, 0 = 24 h
//   s3           count direction, 0 = up, 1 = down
//   out_ore      displayed hours
//   out_minute   displayed minutes
module counter_timp #(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] timp_ore1,
  input  logic [5:0] timp_minute1,
  input  logic [4:0] timp_ore2,
  input  logic [5:0] timp_minute2,
  input  logic       load_1,
  input  logic       load_2,
  input  logic       s12,
  input  logic       s3,
  output logic [4:0] out_ore,
  output logic [5:0] out_minute
);

  // A one-cycle prescaler still needs a 1-bit register to stay legal.
  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_MIN - 1);

  logic [PW-1:0] r_presc;
  logic [4:0]    r_hour;
  logic [5:0]    r_min;

  logic          w_valid1;
  logic          w_valid2;
  logic          w_tick;
  logic [4:0]    w_stepHour;
  logic [5:0]    w_stepMin;

  assign w_valid1 = (timp_ore1 <= 5'd23) && (timp_minute1 <= 6'd59);
  assign w_valid2 = (timp_ore2 <= 5'd23) && (timp_minute2 <= 6'd59);
  assign w_tick   = (r_presc == P_LAST);

  // Time after one minute step in the current direction. Counting down
  // saturates at 00:00 instead of wrapping to 23:59.
  always_comb begin
    w_stepHour = r_hour;
    w_stepMin  = r_min;
    if (!s3) begin
      if (r_min < 6'd59) begin
        w_stepMin = r_min + 6'd1;
      end else begin
        w_stepMin  = 6'd0;
        w_stepHour = (r_hour >= 5'd23) ? 5'd0 : r_hour + 5'd1;
      end
    end else begin
      if (r_min != 6'd0) begin
        w_stepMin = r_min - 6'd1;
      end else if (r_hour != 5'd0) begin
        w_stepMin  = 6'd59;
        w_stepHour = r_hour - 5'd1;
      end
    end
  end

  // An out-of-range source 1 blocks the whole cycle: source 2 is not
  // consulted and nothing counts. A held load keeps reloading.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hour  <= 5'd0;
      r_min   <= 6'd0;
      r_presc <= '0;
    end else if (load_1) begin
      if (w_valid1) begin
        r_hour  <= timp_ore1;
        r_min   <= timp_minute1;
        r_presc <= '0;
      end
    end else if (load_2) begin
      if (w_valid2) begin
        r_hour  <= timp_ore2;
        r_min   <= timp_minute2;
        r_presc <= '0;
      end
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_hour  <= w_stepHour;
        r_min   <= w_stepMin;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // 12 h mode shows midnight as 12 and afternoon hours as 1..11.
  always_comb begin
    out_ore = r_hour;
    if (s12) begin
      if (r_hour == 5'd0) begin
        out_ore = 5'd12;
      end else if (r_hour > 5'd12) begin
        out_ore = r_hour - 5'd12;
      end
    end
  end

  assign out_minute = r_min;

endmodule

// File: tb/tb_counter_timp.sv
// Directed testbench for counter_timp with a 2-cycle minute prescaler.
// Every task starts and ends just after a falling clock edge.
module tb_counter_timp;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] timp_ore1;
  logic [5:0] timp_minute1;
  logic [4:0] timp_ore2;
  logic [5:0] timp_minute2;
  logic       load_1;
  logic       load_2;
  logic       s12;
  logic       s3;
  logic [4:0] out_ore;
  logic [5:0] out_minute;

  int vectors = 0;
  int errors  = 0;

  counter_timp #(.TICKS_PER_MIN(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .timp_ore1    (timp_ore1),
    .timp_minute1 (timp_minute1),
    .timp_ore2    (timp_ore2),
    .timp_minute2 (timp_minute2),
    .load_1       (load_1),
    .load_2       (load_2),
    .s12          (s12),
    .s3           (s3),
    .out_ore      (out_ore),
    .out_minute   (out_minute)
  );

  always #5 clock = ~clock;

  // Let n rising edges pass, then settle on the following falling edge.
  task automatic advance(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  // One-cycle load pulse from source 1.
  task automatic load_src1(input logic [4:0] h, input logic [5:0] m);
    timp_ore1    = h;
    timp_minute1 = m;
    load_1       = 1'b1;
    advance(1);
    load_1 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    load_1 = 1'b1;
    timp_ore1 = 5'd12;
    timp_minute1 = 6'd35;
    advance(3);
    vectors++;
    if ({out_ore, out_minute} !== {5'd0, 6'd0}) begin
      errors++;
      $display("[TB] FAIL reset_24h: got %0d:%0d expected 0:0", out_ore, out_minute);
    end
    s12 = 1'b1;
    #1;
    vectors++;
    if ({out_ore, out_minute} !== {5'd12, 6'd0}) begin
      errors++;
      $display("[TB] FAIL reset_12h: got %0d:%0d expected 12:0", out_ore, out_minute);
    end
    s12 = 1'b0;
    reset = 1'b1;
    load_1 = 1'b0;
    advance(1);
    vectors++;
    if ({out_ore, out_minute} !== {5'd0, 6'd0}) begin
      errors++;
      $display("[TB] FAIL reset_release: got %0d:%0d expected 0:0", out_ore, out_minute);
    end
    advance(1);
    vectors++;
    if ({out_ore, out_minute} !== {5'd0, 6'd1}) begin
      errors++;
      $display("[TB] FAIL first_tick: got %0d:%0d expected 0:1", out_ore, out_minute);
    end
  endtask

  task automatic test_load1;
    s3 = 1'b0;
    load_src1(5'd12, 6'd35);
    vectors++;
    if ({out_ore, out_minute} !== {5'd12, 6'd35}) begin
      errors++;
      $display("[TB] FAIL load1_value: got %0d:%0d expected 12:35", out_ore, out_minute);
    end
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd12, 6'd36}) begin
      errors++;
      $display("[TB] FAIL load1_step1: got %0d:%0d expected 12:36", out_ore, out_minute);
    end
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd12, 6'd37}) begin
      errors++;
      $display("[TB] FAIL load1_step2: got %0d:%0d expected 12:37", out_ore, out_minute);
    end
  endtask

  task automatic test_hold_load;
    timp_ore1 = 5'd8;
    timp_minute1 = 6'd45;
    load_1 = 1'b1;
    advance(5);
    vectors++;
    if ({out_ore, out_minute} !== {5'd8, 6'd45}) begin
      errors++;
      $display("[TB] FAIL hold_load: got %0d:%0d expected 8:45", out_ore, out_minute);
    end
    load_1 = 1'b0;
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd8, 6'd46}) begin
      errors++;
      $display("[TB] FAIL hold_release: got %0d:%0d expected 8:46", out_ore, out_minute);
    end
  endtask

  task automatic test_simultaneous;
    timp_ore1 = 5'd7;
    timp_minute1 = 6'd10;
    timp_ore2 = 5'd9;
    timp_minute2 = 6'd20;
    load_1 = 1'b1;
    load_2 = 1'b1;
    advance(1);
    vectors++;
    if ({out_ore, out_minute} !== {5'd7, 6'd10}) begin
      errors++;
      $display("[TB] FAIL both_loads: got %0d:%0d expected 7:10", out_ore, out_minute);
    end
    timp_ore1 = 5'd24;
    advance(3);
    vectors++;
    if ({out_ore, out_minute} !== {5'd7, 6'd10}) begin
      errors++;
      $display("[TB] FAIL bad_hour1: got %0d:%0d expected 7:10", out_ore, out_minute);
    end
    timp_ore1 = 5'd7;
    timp_minute1 = 6'd60;
    advance(3);
    vectors++;
    if ({out_ore, out_minute} !== {5'd7, 6'd10}) begin
      errors++;
      $display("[TB] FAIL bad_min1: got %0d:%0d expected 7:10", out_ore, out_minute);
    end
    load_1 = 1'b0;
    advance(1);
    vectors++;
    if ({out_ore, out_minute} !== {5'd9, 6'd20}) begin
      errors++;
      $display("[TB] FAIL load2_value: got %0d:%0d expected 9:20", out_ore, out_minute);
    end
    load_2 = 1'b0;
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd9, 6'd21}) begin
      errors++;
      $display("[TB] FAIL load2_step: got %0d:%0d expected 9:21", out_ore, out_minute);
    end
  endtask

  task automatic test_rollover;
    s3 = 1'b0;
    load_src1(5'd23, 6'd59);
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd0, 6'd0}) begin
      errors++;
      $display("[TB] FAIL rollover_24h: got %0d:%0d expected 0:0", out_ore, out_minute);
    end
    s12 = 1'b1;
    #1;
    vectors++;
    if ({out_ore, out_minute} !== {5'd12, 6'd0}) begin
      errors++;
      $display("[TB] FAIL rollover_12h: got %0d:%0d expected 12:0", out_ore, out_minute);
    end
    s12 = 1'b0;
    load_src1(5'd14, 6'd59);
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd15, 6'd0}) begin
      errors++;
      $display("[TB] FAIL hour_carry: got %0d:%0d expected 15:0", out_ore, out_minute);
    end
  endtask

  task automatic test_count_down;
    s3 = 1'b1;
    load_src1(5'd1, 6'd0);
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd0, 6'd59}) begin
      errors++;
      $display("[TB] FAIL down_borrow: got %0d:%0d expected 0:59", out_ore, out_minute);
    end
    load_src1(5'd0, 6'd0);
    advance(6);
    vectors++;
    if ({out_ore, out_minute} !== {5'd0, 6'd0}) begin
      errors++;
      $display("[TB] FAIL down_saturate: got %0d:%0d expected 0:0", out_ore, out_minute);
    end
    load_src1(5'd10, 6'd0);
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd9, 6'd59}) begin
      errors++;
      $display("[TB] FAIL down_10h: got %0d:%0d expected 9:59", out_ore, out_minute);
    end
    s3 = 1'b0;
    advance(2);
    vectors++;
    if ({out_ore, out_minute} !== {5'd10, 6'd0}) begin
      errors++;
      $display("[TB] FAIL dir_change: got %0d:%0d expected 10:0", out_ore, out_minute);
    end
  endtask

  task automatic test_12h;
    s12 = 1'b1;
    load_src1(5'd13, 6'd5);
    vectors++;
    if ({out_ore, out_minute} !== {5'd1, 6'd5}) begin
      errors++;
      $display("[TB] FAIL h12_13: got %0d:%0d expected 1:5", out_ore, out_minute);
    end
    s12 = 1'b0;
    #1;
    vectors++;
    if ({out_ore, out_minute} !== {5'd13, 6'd5}) begin
      errors++;
      $display("[TB] FAIL h24_13: got %0d:%0d expected 13:5", out_ore, out_minute);
    end
    s12 = 1'b1;
    advance(0);
    load_src1(5'd12, 6'd0);
    vectors++;
    if ({out_ore, out_minute} !== {5'd12, 6'd0}) begin
      errors++;
      $display("[TB] FAIL h12_12: got %0d:%0d expected 12:0", out_ore, out_minute);
    end
    load_src1(5'd23, 6'd30);
    vectors++;
    if ({out_ore, out_minute} !== {5'd11, 6'd30}) begin
      errors++;
      $display("[TB] FAIL h12_23: got %0d:%0d expected 11:30", out_ore, out_minute);
    end
    load_src1(5'd1, 6'd0);
    vectors++;
    if ({out_ore, out_minute} !== {5'd1, 6'd0}) begin
      errors++;
      $display("[TB] FAIL h12_1: got %0d:%0d expected 1:0", out_ore, out_minute);
    end
    s12 = 1'b0;
  endtask

  task automatic test_reset_priority;
    load_src1(5'd5, 6'd30);
    timp_ore1 = 5'd6;
    timp_minute1 = 6'd40;
    load_1 = 1'b1;
    reset = 1'b0;
    advance(1);
    vectors++;
    if ({out_ore, out_minute} !== {5'd0, 6'd0}) begin
      errors++;
      $display("[TB] FAIL reset_over_load: got %0d:%0d expected 0:0", out_ore, out_minute);
    end
    reset = 1'b1;
    load_1 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    timp_ore1 = '0;
    timp_minute1 = '0;
    timp_ore2 = '0;
    timp_minute2 = '0;
    load_1 = 1'b0;
    load_2 = 1'b0;
    s12 = 1'b0;
    s3 = 1'b0;
    @(negedge clock);
    test_reset;
    test_load1;
    test_hold_load;
    test_simultaneous;
    test_rollover;
    test_count_down;
    test_12h;
    test_reset_priority;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
